// File: rtl/edge_cache_loader_pkg.sv
// ============================================================================
// Module : edge_cache_loader_pkg
// Brief  : Shared default sizes and FSM state encodings for edge_cache_loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 3
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif
`ifndef DEFAULT_MAX_PENDING
`define DEFAULT_MAX_PENDING 4
`endif
`ifndef ECL_STATE_IDLE
`define ECL_STATE_IDLE  2'd0
`define ECL_STATE_ISSUE 2'd1
`define ECL_STATE_DRAIN 2'd2
`define ECL_STATE_DONE  2'd3
`endif

package edge_cache_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = `ECL_STATE_IDLE,
        ST_ISSUE = `ECL_STATE_ISSUE,
        ST_DRAIN = `ECL_STATE_DRAIN,
        ST_DONE  = `ECL_STATE_DONE
    } state_t;

endpackage

`default_nettype wire

// File: rtl/edge_cache_loader.sv
// ============================================================================
// Module : edge_cache_loader
// Brief  : Streams an N x N adjacency matrix over an Avalon-MM read master
//          into the edge cache write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module edge_cache_loader
    import edge_cache_loader_pkg::*;
#(
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
    parameter int MAX_PENDING = `DEFAULT_MAX_PENDING,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [INDEX_WIDTH:0]       num_nodes,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      avm_address,
    output logic                       avm_read,
    input  logic                       avm_waitrequest,
    input  logic [31:0]                avm_readdata,
    input  logic                       avm_readdatavalid,
    output logic [2*INDEX_WIDTH-1:0]   cache_address,
    output logic                       cache_write_enable,
    output logic [VALUE_WIDTH-1:0]     cache_write_data
);

    localparam int CNT_W  = 2*INDEX_WIDTH + 1;
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    localparam logic [PEND_W-1:0]      C_MAX_PEND   = PEND_W'(MAX_PENDING);
    localparam logic [INDEX_WIDTH:0]   C_MAX_NODES  = (INDEX_WIDTH+1)'(MAX_NODES);
    localparam logic [ADDR_WIDTH-1:0]  C_WORD_BYTES = ADDR_WIDTH'(4);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [INDEX_WIDTH:0]      r_n;
    logic [CNT_W-1:0]          r_total;
    logic [CNT_W-1:0]          r_issued;
    logic [CNT_W-1:0]          r_received;
    logic [PEND_W-1:0]         r_pending;
    logic [INDEX_WIDTH-1:0]    r_wr_to;
    logic [INDEX_WIDTH-1:0]    r_wr_from;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic                      r_we;
    logic [2*INDEX_WIDTH-1:0]  r_cache_addr;
    logic [VALUE_WIDTH-1:0]    r_cache_data;

    logic [INDEX_WIDTH:0]      w_n_sat;
    logic [CNT_W-1:0]          w_n_sq;
    logic                      w_accept;
    logic                      w_resp;
    logic                      w_last_issue;
    logic                      w_wr_to_wrap;

    assign w_n_sat      = (num_nodes > C_MAX_NODES) ? C_MAX_NODES : num_nodes;
    assign w_n_sq       = CNT_W'(w_n_sat) * CNT_W'(w_n_sat);
    assign w_accept     = avm_read && !avm_waitrequest;
    // Responses outside an active load (stale reads after a reset) are dropped.
    assign w_resp       = avm_readdatavalid && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
    assign w_last_issue = w_accept && ((r_issued + 1'b1) == r_total);
    assign w_wr_to_wrap = ({1'b0, r_wr_to} == (r_n - 1'b1));

    assign avm_read           = (r_state == ST_ISSUE) && (r_pending < C_MAX_PEND);
    assign avm_address        = r_addr;
    assign busy               = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign done               = (r_state == ST_DONE);
    assign cache_write_enable = r_we;
    assign cache_address      = r_cache_addr;
    assign cache_write_data   = r_cache_data;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (w_n_sat == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_last_issue) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final write is sitting in the output register this cycle
                // and drains on the same edge that enters DONE.
                if (r_received == r_total) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_n       <= '0;
            r_total   <= '0;
            r_issued  <= '0;
            r_addr    <= '0;
            r_pending <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_n       <= w_n_sat;
                r_total   <= w_n_sq;
                r_issued  <= '0;
                r_addr    <= base_addr;
                r_pending <= '0;
            end else begin
                if (w_accept) begin
                    r_issued <= r_issued + 1'b1;
                    r_addr   <= r_addr + C_WORD_BYTES;
                end
                if (w_accept && !w_resp) begin
                    r_pending <= r_pending + 1'b1;
                end else if (!w_accept && w_resp && (r_pending != '0)) begin
                    r_pending <= r_pending - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_received   <= '0;
            r_wr_to      <= '0;
            r_wr_from    <= '0;
            r_we         <= 1'b0;
            r_cache_addr <= '0;
            r_cache_data <= '0;
        end else begin
            r_we <= w_resp;
            if ((r_state == ST_IDLE) && start) begin
                r_received <= '0;
                r_wr_to    <= '0;
                r_wr_from  <= '0;
            end else if (w_resp) begin
                r_received   <= r_received + 1'b1;
                r_cache_addr <= {r_wr_to, r_wr_from};
                r_cache_data <= avm_readdata[VALUE_WIDTH-1:0];
                if (w_wr_to_wrap) begin
                    r_wr_to   <= '0;
                    r_wr_from <= r_wr_from + 1'b1;
                end else begin
                    r_wr_to   <= r_wr_to + 1'b1;
                end
            end
        end
    end

    generate
        if (VALUE_WIDTH < 32) begin : g_unused_readdata
            logic unused_readdata_bits;
            assign unused_readdata_bits = ^avm_readdata[31:VALUE_WIDTH];
        end
    endgenerate

endmodule

`default_nettype wire
